// File: rtl/temp_pkg.sv
// temp_pkg: shared state encoding, temperature bounds and widths for the temperature control blocks
package temp_pkg;
    typedef enum logic [1:0] {IDLE, ESPERA, SOLICITA, CAPTURA} estado_t;
    localparam int TEMP_W        = 11;
    localparam int CNT_W         = 3;
    localparam int TEMP_FRIO_DEF = 180;
    localparam int TEMP_ALTO_DEF = 250;
endpackage

// File: rtl/temp_evaluador.sv
// temp_evaluador: signed normal-range check plus saturating out-of-range persistence counter update
module temp_evaluador import temp_pkg::*; #(
    parameter int TEMP_FRIO = TEMP_FRIO_DEF,
    parameter int TEMP_ALTO = TEMP_ALTO_DEF,
    parameter int CNT_MAX   = 7
) (
    input  logic signed [TEMP_W-1:0] valor,
    input  logic [CNT_W-1:0]         cnt,
    output logic                     fuera,
    output logic [CNT_W-1:0]         cnt_next
);
    always_comb begin
        fuera    = (int'(valor) < TEMP_FRIO) || (int'(valor) > TEMP_ALTO);
        cnt_next = !fuera ? '0 : (int'(cnt) >= CNT_MAX) ? cnt : cnt + 1'b1;
    end
endmodule

// File: rtl/control_muestreo_temp.sv
// control_muestreo_temp: periodic sensor req/ack sampler with range persistence counter and timeout flags
// Optional FILTRO_PROMEDIO_EN: store the average of the previous raw sample and the new one.
module control_muestreo_temp import temp_pkg::*; #(
    parameter int PERIODO   = 1000,
    parameter int TIMEOUT   = 64,
    parameter int TEMP_FRIO = TEMP_FRIO_DEF,
    parameter int TEMP_ALTO = TEMP_ALTO_DEF,
    parameter int CNT_MAX   = 7
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              habilitar,
    output logic              sensor_req,
    input  logic              sensor_ack,
    input  logic [TEMP_W-1:0] sensor_dato,
    output logic [TEMP_W-1:0] temp_registrado,
    output logic [CNT_W-1:0]  contador_fuera_rango,
    output logic              muestra_valida,
    output logic              error_sensor,
    output logic [3:0]        fallos
);
    localparam int PW = $clog2(PERIODO + 1);
    localparam int TW = $clog2(TIMEOUT + 1);

    estado_t                  estado_q, estado_d;
    logic [PW-1:0]            timer_q, timer_d;
    logic [TW-1:0]            to_q, to_d;
    logic signed [TEMP_W-1:0] dato_q, dato_d, temp_q, temp_d, valor;
    logic [CNT_W-1:0]         cnt_q, cnt_d, cnt_next;
    logic                     mv_q, mv_d, err_q, err_d, fuera;
    logic [3:0]               fallos_q, fallos_d;

    temp_evaluador #(.TEMP_FRIO(TEMP_FRIO), .TEMP_ALTO(TEMP_ALTO), .CNT_MAX(CNT_MAX)) u_eval (
        .valor(valor), .cnt(cnt_q), .fuera(fuera), .cnt_next(cnt_next)
    );

`ifdef FILTRO_PROMEDIO_EN
    logic signed [TEMP_W-1:0] prev_q, prev_d;
    logic                     prev_ok_q, prev_ok_d;
    logic signed [TEMP_W:0]   suma;
    // Dropping the sum's LSB is an arithmetic shift, so odd negative sums round toward -inf.
    always_comb begin
        suma      = $signed({dato_q[TEMP_W-1], dato_q}) + $signed({prev_q[TEMP_W-1], prev_q});
        valor     = prev_ok_q ? suma[TEMP_W:1] : dato_q;
        prev_d    = (estado_q == CAPTURA) ? dato_q : prev_q;
        prev_ok_d = prev_ok_q | (estado_q == CAPTURA);
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            prev_q    <= '0;
            prev_ok_q <= 1'b0;
        end else begin
            prev_q    <= prev_d;
            prev_ok_q <= prev_ok_d;
        end
    end
`else
    assign valor = dato_q;
`endif

    always_comb begin
        estado_d = estado_q;
        timer_d  = timer_q;
        to_d     = to_q;
        dato_d   = dato_q;
        temp_d   = temp_q;
        cnt_d    = cnt_q;
        mv_d     = 1'b0;
        err_d    = err_q;
        fallos_d = fallos_q;
        case (estado_q)
            IDLE: begin
                estado_d = habilitar ? ESPERA : IDLE;
                timer_d  = '0;
            end
            ESPERA: begin
                timer_d = timer_q + 1'b1;
                if (!habilitar) estado_d = IDLE;
                else if (timer_q == PW'(PERIODO - 1)) begin
                    estado_d = SOLICITA;
                    to_d     = '0;
                end
            end
            // An ack on the last allowed cycle still wins over the timeout.
            SOLICITA: begin
                if (sensor_ack) begin
                    estado_d = CAPTURA;
                    dato_d   = sensor_dato;
                end else if (to_q == TW'(TIMEOUT - 1)) begin
                    estado_d = ESPERA;
                    timer_d  = '0;
                    err_d    = 1'b1;
                    fallos_d = fallos_q + {3'b000, fallos_q != 4'hF};
                end else to_d = to_q + 1'b1;
            end
            CAPTURA: begin
                temp_d   = valor;
                cnt_d    = cnt_next;
                mv_d     = 1'b1;
                err_d    = 1'b0;
                timer_d  = '0;
                estado_d = habilitar ? ESPERA : IDLE;
            end
            default: estado_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            estado_q <= IDLE;
            timer_q  <= '0;
            to_q     <= '0;
            dato_q   <= '0;
            temp_q   <= '0;
            cnt_q    <= '0;
            mv_q     <= 1'b0;
            err_q    <= 1'b0;
            fallos_q <= '0;
        end else begin
            estado_q <= estado_d;
            timer_q  <= timer_d;
            to_q     <= to_d;
            dato_q   <= dato_d;
            temp_q   <= temp_d;
            cnt_q    <= cnt_d;
            mv_q     <= mv_d;
            err_q    <= err_d;
            fallos_q <= fallos_d;
        end
    end

    assign sensor_req           = (estado_q == SOLICITA);
    assign temp_registrado      = temp_q;
    assign contador_fuera_rango = cnt_q;
    assign muestra_valida       = mv_q;
    assign error_sensor         = err_q;
    assign fallos               = fallos_q;
endmodule

// File: tb/tb_control_muestreo_temp.sv
// tb_control_muestreo_temp: directed stimulus, cycle-by-cycle comparison against a behavioural sampler model
module tb_control_muestreo_temp;
    localparam int PERIODO = 10;
    localparam int TIMEOUT = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        habilitar = 1'b0;
    logic        sensor_req;
    logic        sensor_ack = 1'b0;
    logic [10:0] sensor_dato = '0;
    logic [10:0] temp_registrado;
    logic [2:0]  contador_fuera_rango;
    logic        muestra_valida;
    logic        error_sensor;
    logic [3:0]  fallos;

    int n_chk = 0;
    int n_fail = 0;

    control_muestreo_temp #(.PERIODO(PERIODO), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst), .habilitar(habilitar),
        .sensor_req(sensor_req), .sensor_ack(sensor_ack), .sensor_dato(sensor_dato),
        .temp_registrado(temp_registrado), .contador_fuera_rango(contador_fuera_rango),
        .muestra_valida(muestra_valida), .error_sensor(error_sensor), .fallos(fallos)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Behavioural model: counts cycles left before a request, request age, and pending capture.
    int m_left, m_age, m_lat, m_temp, m_cnt, m_fal;
    bit m_req, m_cap, m_err, m_mv, m_on;
`ifdef FILTRO_PROMEDIO_EN
    int m_prev;
    bit m_have;
    function automatic int floor_half(input int s);
        return (s >= 0) ? s / 2 : -((-s + 1) / 2);
    endfunction
`endif

    always @(posedge clk) begin
        int v;
        m_mv = 1'b0;
        if (rst) begin
            m_on = 1'b1; m_left = 0; m_age = 0; m_req = 1'b0; m_cap = 1'b0;
            m_err = 1'b0; m_temp = 0; m_cnt = 0; m_fal = 0;
`ifdef FILTRO_PROMEDIO_EN
            m_have = 1'b0; m_prev = 0;
`endif
        end else if (m_cap) begin
            v = m_lat;
`ifdef FILTRO_PROMEDIO_EN
            if (m_have) v = floor_half(m_prev + m_lat);
            m_prev = m_lat;
            m_have = 1'b1;
`endif
            m_temp = v;
            m_cnt = (v < 180 || v > 250) ? ((m_cnt < 7) ? m_cnt + 1 : 7) : 0;
            m_err = 1'b0;
            m_mv = 1'b1;
            m_cap = 1'b0;
            m_left = habilitar ? PERIODO : 0;
        end else if (m_req) begin
            if (sensor_ack) begin
                m_req = 1'b0;
                m_cap = 1'b1;
                m_lat = int'($signed(sensor_dato));
            end else begin
                m_age++;
                if (m_age == TIMEOUT) begin
                    m_req = 1'b0;
                    m_err = 1'b1;
                    m_fal = (m_fal < 15) ? m_fal + 1 : 15;
                    m_left = PERIODO;
                end
            end
        end else if (m_left > 0) begin
            if (!habilitar) m_left = 0;
            else begin
                m_left--;
                if (m_left == 0) begin
                    m_req = 1'b1;
                    m_age = 0;
                end
            end
        end else if (habilitar) m_left = PERIODO;
    end

    always @(negedge clk) begin
        if (m_on) begin
            chk("m_sensor_req", int'(sensor_req), int'(m_req));
            chk("m_temp_registrado", int'($signed(temp_registrado)), m_temp);
            chk("m_contador", int'(contador_fuera_rango), m_cnt);
            chk("m_muestra_valida", int'(muestra_valida), int'(m_mv));
            chk("m_error_sensor", int'(error_sensor), int'(m_err));
            chk("m_fallos", int'(fallos), m_fal);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_req(output int n);
        n = 0;
        while (!sensor_req && n < 200) begin
            tick();
            n++;
        end
        if (!sensor_req) chk("wait_req_timeout", 0, 1);
    endtask

    task automatic sample(input string nm, input int d, input int dato, input int exp_t, input int exp_c);
        int n;
        wait_req(n);
        repeat (d) tick();
        sensor_ack = 1'b1;
        sensor_dato = dato[10:0];
        tick();
        sensor_ack = 1'b0;
        tick();
        chk({nm, "_temp"}, int'($signed(temp_registrado)), exp_t);
        chk({nm, "_cnt"}, int'(contador_fuera_rango), exp_c);
        chk({nm, "_mv"}, int'(muestra_valida), 1);
        chk({nm, "_err"}, int'(error_sensor), 0);
        tick();
        chk({nm, "_mv_once"}, int'(muestra_valida), 0);
    endtask

    task automatic timeout_run(output int n);
        int w;
        wait_req(w);
        n = 0;
        while (sensor_req && n < 50) begin
            tick();
            n++;
        end
    endtask

    initial begin
        int n;
        #200000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1);
    end

    initial begin
        int n;
        rst = 1'b1;
        tick();
        tick();
        chk("rst_req", int'(sensor_req), 0);
        chk("rst_temp", int'(temp_registrado), 0);
        chk("rst_fallos", int'(fallos), 0);
        rst = 1'b0;
        habilitar = 1'b1;
        wait_req(n);
        chk("req_delay", n, 11);
        sample("first", 3, 200, 200, 0);
`ifdef FILTRO_PROMEDIO_EN
        sample("filt_neg", 1, -10, 95, 1);
        sample("filt_m3", 1, -3, -7, 2);
        sample("filt_m4", 1, -4, -4, 3);
        sample("filt_in", 1, 220, 108, 4);
`else
        for (int i = 0; i < 8; i++) sample("cold100", 1, 100, 100, (i < 7) ? i + 1 : 7);
        sample("in220", 2, 220, 220, 0);
        sample("hot260", 0, 260, 260, 1);
        sample("cold170", 1, 170, 170, 2);
        sample("hot300", 1, 300, 300, 3);
        sample("edge180", 1, 180, 180, 0);
        sample("edge250", 1, 250, 250, 0);
        sample("neg_cold", 1, -40, -40, 1);
        sample("edge250b", 1, 250, 250, 0);
`endif
        n = 0;
        begin
            int t_before;
            t_before = int'($signed(temp_registrado));
            timeout_run(n);
            chk("to_req_len", n, 8);
            chk("to_err", int'(error_sensor), 1);
            chk("to_fallos1", int'(fallos), 1);
            chk("to_temp_kept", int'($signed(temp_registrado)), t_before);
        end
        for (int i = 0; i < 15; i++) timeout_run(n);
        chk("to_fallos_sat", int'(fallos), 15);
        chk("to_err_still", int'(error_sensor), 1);
        sample("recover", 7, 210, 210, 0);
        chk("recover_fallos", int'(fallos), 15);
        wait_req(n);
        habilitar = 1'b0;
        repeat (2) tick();
        sensor_ack = 1'b1;
        sensor_dato = 11'd190;
        tick();
        sensor_ack = 1'b0;
        tick();
        chk("drop_temp", int'(temp_registrado), 190);
        chk("drop_mv", int'(muestra_valida), 1);
        n = 0;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (sensor_req) n++;
        end
        chk("drop_no_req", n, 0);
        habilitar = 1'b1;
        wait_req(n);
        tick();
        rst = 1'b1;
        tick();
        chk("midrst_req", int'(sensor_req), 0);
        chk("midrst_temp", int'(temp_registrado), 0);
        chk("midrst_cnt", int'(contador_fuera_rango), 0);
        chk("midrst_err", int'(error_sensor), 0);
        chk("midrst_fallos", int'(fallos), 0);
        chk("midrst_mv", int'(muestra_valida), 0);
        rst = 1'b0;
        habilitar = 1'b0;
        repeat (3) tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
